// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the cache access controller.
//   state_t      - controller FSM states (IDLE, WRITE_BACK, ALLOCATE)
//   CTRL_*       - bit positions inside the 6-bit control word to the sets,
//                  ordered {write_en, update_en, set_valid, set_dirty,
//                  strategy_en, offset_sel}
//   CTRL_<name>  - complete control words for each kind of cycle
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2
    } state_t;

    localparam int CTRL_WRITE_EN    = 5;
    localparam int CTRL_UPDATE_EN   = 4;
    localparam int CTRL_SET_VALID   = 3;
    localparam int CTRL_SET_DIRTY   = 2;
    localparam int CTRL_STRATEGY_EN = 1;
    localparam int CTRL_OFFSET_SEL  = 0;

    localparam logic [5:0] CTRL_IDLE        = 6'b000000;
    // Read hit: only select the processor offset for the read mux.
    localparam logic [5:0] CTRL_READ_HIT    = 6'b000001;
    // Write hit: write the word, mark valid+dirty, touch LRU.
    localparam logic [5:0] CTRL_WRITE_HIT   = 6'b111111;
    // Refill word: write memory data at the memory-address offset.
    localparam logic [5:0] CTRL_REFILL      = 6'b100000;
    // Last refill word: also install the tag, set valid, clear dirty, touch LRU.
    localparam logic [5:0] CTRL_REFILL_LAST = 6'b111010;

endpackage

// File: rtl/cache_stats.sv
// cache_stats: hit/miss statistics counters for the cache controller.
// Ports:
//   clk_i, rst_i      - clock, synchronous active-high reset (clears counts)
//   hit_evt_i         - one pulse per counted hit cycle
//   miss_evt_i        - one pulse per miss (IDLE -> refill path transition)
//   hit_count_o       - number of hits, wraps modulo 2^32
//   miss_count_o      - number of misses, wraps modulo 2^32
module cache_stats (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        hit_evt_i,
    input  logic        miss_evt_i,
    output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
);

    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (hit_evt_i) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (miss_evt_i) begin
            miss_count_d = miss_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;

endmodule

// File: rtl/cache_controller.sv
// cache_controller: per-access control FSM for the set-associative cache.
// Drives the sets' 6-bit control word and the memory-side word address, and
// runs the memory handshake on a miss (dirty victim write-back, then refill).
// Build option: define CACHE_STATS_EN to get live hit/miss counters;
// otherwise hit_count_o/miss_count_o are constant 0.
// Ports:
//   clk_i, rst_i           - clock, synchronous active-high reset
//   read_en_i, write_en_i  - processor request (both high = write)
//   addr_i                 - request address, held stable while stall_o=1
//   hit_i, dirty_i         - status of the indexed set
//   tag_dirty_line_i       - tag of the victim line (write-back address)
//   mem_ready_i            - memory transferred one word this cycle
//   control_o              - {write_en, update_en, set_valid, set_dirty,
//                             strategy_en, offset_sel} to the sets
//   mem_addr_o             - word address to memory / refill offset
//   mem_read_en_o          - refill word request
//   mem_write_en_o         - write-back word request
//   stall_o                - processor must hold its request
//   hit_count_o, miss_count_o - statistics
//   state_o                - current FSM state (debug visibility)
// Memory handshake: an en/address pair stays asserted and stable until
// mem_ready_i is sampled high on a clock edge; one word moves per such edge,
// so back-to-back words are legal.
`ifndef CACHE_T
`define CACHE_T 20
`endif
`ifndef CACHE_S
`define CACHE_S 8
`endif
`ifndef CACHE_B
`define CACHE_B 4
`endif

module cache_controller
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH    = `CACHE_T,
    parameter int SET_WIDTH    = `CACHE_S,
    parameter int OFFSET_WIDTH = `CACHE_B
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 read_en_i,
    input  logic                 write_en_i,
    input  logic [31:0]          addr_i,
    input  logic                 hit_i,
    input  logic                 dirty_i,
    input  logic [TAG_WIDTH-1:0] tag_dirty_line_i,
    input  logic                 mem_ready_i,
    output logic [5:0]           control_o,
    output logic [31:0]          mem_addr_o,
    output logic                 mem_read_en_o,
    output logic                 mem_write_en_o,
    output logic                 stall_o,
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o,
    output state_t               state_o
);

    localparam int CNT_W = OFFSET_WIDTH - 2;
    localparam logic [CNT_W-1:0] CNT_LAST = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic                 req;
    logic [SET_WIDTH-1:0] req_index;
    logic [TAG_WIDTH-1:0] req_tag;
    logic                 cnt_is_last;

    // Byte-offset bits never leave this block: word addresses come from cnt.
    logic unused_offset;
    assign unused_offset = ^addr_i[OFFSET_WIDTH-1:0];

    assign req         = read_en_i | write_en_i;
    assign req_index   = addr_i[OFFSET_WIDTH +: SET_WIDTH];
    assign req_tag     = addr_i[31 -: TAG_WIDTH];
    assign cnt_is_last = (cnt_q == CNT_LAST);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        control_o      = CTRL_IDLE;
        mem_addr_o     = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        stall_o        = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit_i) begin
                        control_o = write_en_i ? CTRL_WRITE_HIT : CTRL_READ_HIT;
                    end else begin
                        stall_o = 1'b1;
                        cnt_d   = '0;
                        state_d = dirty_i ? WRITE_BACK : ALLOCATE;
                    end
                end
            end

            WRITE_BACK: begin
                stall_o        = 1'b1;
                mem_write_en_o = 1'b1;
                mem_addr_o     = 32'({tag_dirty_line_i, req_index, cnt_q, 2'b00});
                if (mem_ready_i) begin
                    if (cnt_is_last) begin
                        cnt_d   = '0;
                        state_d = ALLOCATE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            ALLOCATE: begin
                stall_o       = 1'b1;
                mem_read_en_o = 1'b1;
                mem_addr_o    = 32'({req_tag, req_index, cnt_q, 2'b00});
                if (mem_ready_i) begin
                    if (cnt_is_last) begin
                        // Only the final word validates the line, so an
                        // interrupted refill leaves it invalid.
                        control_o = CTRL_REFILL_LAST;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        control_o = CTRL_REFILL;
                        cnt_d     = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

`ifdef CACHE_STATS_EN
    logic hit_evt;
    logic miss_evt;

    // The post-refill re-evaluation is an ordinary IDLE hit and is counted.
    assign hit_evt  = (state_q == IDLE) && req && hit_i;
    assign miss_evt = (state_q == IDLE) && req && !hit_i;

    cache_stats u_stats (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .hit_evt_i    (hit_evt),
        .miss_evt_i   (miss_evt),
        .hit_count_o  (hit_count_o),
        .miss_count_o (miss_count_o)
    );
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif

endmodule
